// File: rtl/gat_pkg.sv
// Shared definitions for the GAT feature memories: depth/address-width derivations
// and the reader FSM state type, so the memory controller and readers agree.
package gat_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } feat_rd_state_e;

    function automatic int feat_depth(input int num_subgraphs, input int num_feature_out);
        return num_subgraphs * num_feature_out;
    endfunction

    // A one-word memory still needs a one-bit address port.
    function automatic int feat_addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/feat_rd_fifo.sv
// Two-entry synchronous FIFO used as the skid buffer between the BRAM read
// pipeline and the output stream. Same-cycle push and pop are supported.
module feat_rd_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // NOTE: the two storage words are reset along with the pointers so the head
    // word, which drives the stream data directly, reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

endmodule

// File: rtl/feat_bram_reader.sv
// Drains a range of the new-feature BRAM onto a valid/ready stream, hiding the
// BRAM's one-cycle read latency behind a credit-limited two-entry FIFO.
module feat_bram_reader
    import gat_pkg::*;
#(
    parameter  int NEW_FEATURE_WIDTH  = 32,
    parameter  int NUM_SUBGRAPHS      = 2708,
    parameter  int NUM_FEATURE_OUT    = 16,
    localparam int NEW_FEATURE_DEPTH  = feat_depth(NUM_SUBGRAPHS, NUM_FEATURE_OUT),
    localparam int NEW_FEATURE_ADDR_W = feat_addr_w(NEW_FEATURE_DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
    output logic                          busy,
    output logic                          done,
    output logic [NEW_FEATURE_ADDR_W-1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast
);

    localparam int AW = NEW_FEATURE_ADDR_W;
    localparam int CW = NEW_FEATURE_ADDR_W + 1;

    feat_rd_state_e state_q;
    feat_rd_state_e state_d;

    logic [CW-1:0] len_q;
    logic [CW-1:0] len_clamped;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] sent_cnt;
    logic [AW-1:0] addr_q;
    logic          inflight_q;
    logic          do_issue;
    logic          pop;
    logic [2:0]    occupancy;

    logic          fifo_push;
    logic [1:0]    fifo_count;
    logic          fifo_empty;
    logic          fifo_full;

    assign len_clamped = (num_words > CW'(NEW_FEATURE_DEPTH)) ? CW'(NEW_FEATURE_DEPTH) : num_words;

    assign pop = m_tvalid & m_tready;

    // Words already owned by the FIFO after this cycle, counting the read in flight.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

    assign do_issue = (state_q == RUN) && (issue_cnt < len_q) && (occupancy < 3'd2);

    assign feat_bram_addrb = do_issue ? issue_cnt[AW-1:0] : addr_q;

    // The credit rule keeps the FIFO from being full here; the guard only
    // protects the stored head word should that invariant ever be broken.
    assign fifo_push = inflight_q && (!fifo_full || pop);

    feat_rd_fifo #(
        .WIDTH (NEW_FEATURE_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (feat_bram_dout),
        .pop       (pop),
        .head      (m_tdata),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tlast  = m_tvalid && (sent_cnt == (len_q - CW'(1)));

    assign busy = (state_q == RUN);
    assign done = (state_q == FINISH);

    // NOTE: state and counters use non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d is assigned before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len_clamped == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (pop && m_tlast) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            issue_cnt  <= '0;
            sent_cnt   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            addr_q     <= feat_bram_addrb;
            inflight_q <= do_issue;
            if (state_q == IDLE) begin
                if (start) begin
                    len_q     <= len_clamped;
                    issue_cnt <= '0;
                    sent_cnt  <= '0;
                end
            end else if (state_q == RUN) begin
                if (do_issue) begin
                    issue_cnt <= issue_cnt + CW'(1);
                end
                if (pop) begin
                    sent_cnt <= sent_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_feat_bram_reader.sv
// Directed bench for feat_bram_reader: a queue-based model of the expected beat
// sequence and handshake timing is checked every cycle, plus literal timing pins.
module tb_feat_bram_reader;

    localparam int WIDTH = 32;
    localparam int NSG   = 3;
    localparam int NFO   = 4;
    localparam int DEPTH = NSG * NFO;
    localparam int AW    = 4;
    localparam int CW    = AW + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CW-1:0]    num_words = '0;
    logic             busy;
    logic             done;
    logic [AW-1:0]    feat_bram_addrb;
    logic [WIDTH-1:0] feat_bram_dout = '0;
    logic [WIDTH-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready = 1'b1;
    logic             m_tlast;

    feat_bram_reader #(
        .NEW_FEATURE_WIDTH (WIDTH),
        .NUM_SUBGRAPHS     (NSG),
        .NUM_FEATURE_OUT   (NFO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .num_words       (num_words),
        .busy            (busy),
        .done            (done),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_dout  (feat_bram_dout),
        .m_tdata         (m_tdata),
        .m_tvalid        (m_tvalid),
        .m_tready        (m_tready),
        .m_tlast         (m_tlast)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM contents are addr + 0x100, read latency one cycle.
    always @(posedge clk) feat_bram_dout <= 32'h100 + WIDTH'(feat_bram_addrb);

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Model state and transfer log.
    int         exp_q[$];
    int         m_len;
    int         m_sent;
    int         start_cyc = -100;
    int         done_due = -1;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic       prev_last = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic       exp_busy;

    int beats, first_cyc, last_cyc, tlast_cnt, tlast_cyc, done_count, done_cyc;
    logic [WIDTH-1:0] first_data, last_data;

    task automatic clear_log();
        beats = 0; first_cyc = -1; last_cyc = -1; tlast_cnt = 0; tlast_cyc = -1;
        done_count = 0; done_cyc = -1; first_data = '0; last_data = '0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {busy, done, m_tvalid, m_tlast, feat_bram_addrb, m_tdata}, 64'd0);
            exp_q.delete();
            m_sent = 0;
            start_cyc = -100;
            done_due = -1;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_addr = '0;
        end else begin
            exp_busy = (cyc > start_cyc) && (cyc < done_due);
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(cyc == done_due));
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end

            if (exp_busy && cyc == start_cyc + 1)
                check("addr_first", 64'(feat_bram_addrb), 64'd0);
            else if (exp_busy) begin
                check("addr_step", 64'(feat_bram_addrb == prev_addr || feat_bram_addrb == prev_addr + 1'b1), 64'd1);
                check("outstanding", 64'((int'(feat_bram_addrb) + 1 - m_sent) <= 3), 64'd1);
            end else
                check("addr_hold", 64'(feat_bram_addrb), 64'(prev_addr));

            if (prev_valid && !prev_ready) begin
                check("hold_valid", 64'(m_tvalid), 64'd1);
                check("hold_data", 64'(m_tdata), 64'(prev_data));
                check("hold_last", 64'(m_tlast), 64'(prev_last));
            end

            if (m_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 64'(m_tvalid), 64'd0);
                end else begin
                    check("tdata", 64'(m_tdata), 64'(exp_q[0]));
                    check("tlast", 64'(m_tlast), 64'(exp_q.size() == 1));
                    if (m_tready) begin
                        if (beats == 0) begin
                            first_cyc = cyc;
                            first_data = m_tdata;
                        end
                        last_cyc = cyc;
                        last_data = m_tdata;
                        if (m_tlast) begin
                            tlast_cnt++;
                            tlast_cyc = cyc;
                        end
                        beats++;
                        m_sent++;
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) done_due = cyc + 1;
                    end
                end
            end

            prev_valid = m_tvalid;
            prev_ready = m_tready;
            prev_data = m_tdata;
            prev_last = m_tlast;
            prev_addr = feat_bram_addrb;

            if (start && !busy && !done) begin
                m_len = (int'(num_words) > DEPTH) ? DEPTH : int'(num_words);
                exp_q.delete();
                for (int i = 0; i < m_len; i++) exp_q.push_back(32'h100 + i);
                m_sent = 0;
                start_cyc = cyc;
                done_due = (m_len == 0) ? cyc + 1 : 1 << 30;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int nw, output int t);
        num_words = CW'(nw);
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (done_count == 0 && n < max_cycles) begin
            tick();
            n++;
        end
        if (done_count == 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t;
    int t2;
    logic [AW-1:0] addr_snap;
    logic [AW-1:0] addr_mid;
    logic ready_pat [18];

    initial begin
        clear_log();
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addrb", 64'(feat_bram_addrb), 64'd0);
        check("rst_tdata", 64'(m_tdata), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tlast", 64'(m_tlast), 64'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Basic stream of 5 words.
        clear_log();
        m_tready = 1'b1;
        do_start(5, t);
        wait_done(40);
        check("basic_beats", 64'(beats), 64'd5);
        check("basic_first_cyc", 64'(first_cyc), 64'(t + 3));
        check("basic_first_data", 64'(first_data), 64'h100);
        check("basic_last_cyc", 64'(last_cyc), 64'(t + 7));
        check("basic_last_data", 64'(last_data), 64'h104);
        check("basic_tlast_cyc", 64'(tlast_cyc), 64'(t + 7));
        check("basic_tlast_cnt", 64'(tlast_cnt), 64'd1);
        check("basic_done_cyc", 64'(done_cyc), 64'(t + 8));
        tick();
        tick();

        // Backpressure: 1,0,0,1,1,0,0,1 then ten low cycles, then high.
        ready_pat = '{1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        clear_log();
        m_tready = 1'b1;
        do_start(6, t);
        for (int i = 0; i < 18; i++) begin
            m_tready = ready_pat[i];
            if (i == 11) addr_snap = feat_bram_addrb;
            if (i == 17) addr_mid = feat_bram_addrb;
            tick();
        end
        check("bp_addr_stall", 64'(addr_mid), 64'(addr_snap));
        m_tready = 1'b1;
        wait_done(40);
        check("bp_beats", 64'(beats), 64'd6);
        check("bp_first_data", 64'(first_data), 64'h100);
        check("bp_last_data", 64'(last_data), 64'h105);
        check("bp_tlast_cnt", 64'(tlast_cnt), 64'd1);
        check("bp_done_cnt", 64'(done_count), 64'd1);
        tick();
        tick();

        // Zero length.
        clear_log();
        addr_snap = feat_bram_addrb;
        do_start(0, t);
        wait_done(10);
        check("zero_done_cyc", 64'(done_cyc), 64'(t + 1));
        check("zero_beats", 64'(beats), 64'd0);
        check("zero_addr", 64'(feat_bram_addrb), 64'(addr_snap));
        tick();
        tick();

        // Clamp to DEPTH, with a second start ignored while busy.
        clear_log();
        do_start(DEPTH + 10, t);
        repeat (4) tick();
        do_start(3, t2);
        wait_done(100);
        repeat (4) tick();
        check("clamp_beats", 64'(beats), 64'(DEPTH));
        check("clamp_last_data", 64'(last_data), 64'(32'h100 + DEPTH - 1));
        check("clamp_last_addr", 64'(feat_bram_addrb), 64'(DEPTH - 1));
        check("clamp_done_cnt", 64'(done_count), 64'd1);
        check("clamp_done_cyc", 64'(done_cyc), 64'(t + DEPTH + 3));

        // Reset during the third word of an 8-word transfer.
        clear_log();
        do_start(8, t);
        for (int n = 0; n < 30 && beats < 2; n++) tick();
        check("rst_mid_reached", 64'(beats), 64'd2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {busy, done, m_tvalid, m_tlast, feat_bram_addrb, m_tdata}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        do_start(2, t);
        wait_done(20);
        check("post_rst_beats", 64'(beats), 64'd2);
        check("post_rst_first", 64'(first_data), 64'h100);
        check("post_rst_last", 64'(last_data), 64'h101);
        check("post_rst_done_cyc", 64'(done_cyc), 64'(t + 5));
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/feat_bram_reader.md
# feat_bram_reader

Read-out engine for the new-feature BRAM. On a start pulse it sweeps the PL read port of that BRAM over a requested number of words. It absorbs the BRAM's one-cycle read latency and streams the words to the PS side over a valid/ready interface with backpressure and last-beat marking. It is the consumer counterpart of the feature write path: conv layers write features in, and this block drains them out.

## Interface
Parameters:
- NEW_FEATURE_WIDTH, 32, feature word width
- NUM_SUBGRAPHS, 2708, number of subgraphs
- NUM_FEATURE_OUT, 16, output features per subgraph
- NEW_FEATURE_DEPTH, NUM_SUBGRAPHS*NUM_FEATURE_OUT, BRAM depth (derived, local)
- NEW_FEATURE_ADDR_W, $clog2(NEW_FEATURE_DEPTH), address width (derived, local)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  single-cycle request; ignored while busy=1
- num_words  in  NEW_FEATURE_ADDR_W+1  word count, sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  single-cycle pulse when a transfer ends
- feat_bram_addrb  out  NEW_FEATURE_ADDR_W  BRAM read address
- feat_bram_dout  in  NEW_FEATURE_WIDTH  BRAM read data, valid one cycle after the address
- m_tdata  out  NEW_FEATURE_WIDTH  stream data
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tlast  out  1  high with the final word of the transfer

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - On start, latch len = min(num_words, NEW_FEATURE_DEPTH).
  - Clear issue_cnt and sent_cnt.
  - If len = 0, go to FINISH. Otherwise go to RUN.
- RUN, read issue:
  - A read is issued when issue_cnt < len and (fifo_count + inflight − pop) < 2.
  - pop = m_tvalid & m_tready. inflight = 1 if a read was issued in the previous cycle.
  - On a read, feat_bram_addrb = issue_cnt and issue_cnt increments.
  - When no read is issued, addrb holds its last value.
- RUN, capture and send:
  - inflight data is pushed into the 2-entry FIFO the cycle after issue. This push never overflows, because the credit rule above guarantees space.
  - The FIFO head drives m_tdata. m_tvalid = FIFO not empty.
  - m_tlast = m_tvalid & (sent_cnt == len−1).
  - sent_cnt increments on each pop.
- RUN → FINISH: on the pop where m_tlast = 1.
- FINISH: assert done for one cycle, drop busy, return to IDLE.
- AXI-stream rule: once m_tvalid is high, m_tdata and m_tlast hold stable until the beat is accepted.
- Addresses are issued strictly in ascending order from 0. They never wrap, since len ≤ DEPTH.
- If start arrives in FINISH or RUN, it is dropped (no queueing).
- Async reset mid-transfer:
  - The FIFO, counters and FSM clear immediately.
  - Outputs go to their reset values.
  - In-flight BRAM data is discarded.

## Timing
- Reset values: busy=0, done=0, feat_bram_addrb=0, m_tdata=0, m_tvalid=0, m_tlast=0. FSM returns to IDLE.
- Start sampled at cycle T:
  - addr 0 is issued at T+1.
  - BRAM data is captured at T+2.
  - m_tvalid first goes high at T+3.
- Throughput with m_tready held high: 1 word/cycle sustained.
- Full transfer of N words with m_tready=1: last beat at T+N+2, done at T+N+3.
- len = 0: done pulses at T+1. No beats are sent and no BRAM reads are issued.
- Under backpressure, at most 2 words are buffered plus 1 in flight. Issue stalls until a slot is free.
- When m_tready is reasserted, a beat is accepted in that same cycle. There is no bubble.

## Structure
- Shared package gat_pkg:
  - NEW_FEATURE_DEPTH and NEW_FEATURE_ADDR_W derivations, so this block and the memory controller stay consistent.
  - FSM state typedef feat_rd_state_e {IDLE, RUN, FINISH}.
- Sub-module feat_rd_fifo:
  - 2-entry synchronous FIFO with same-cycle push/pop.
  - Provides count, empty and full outputs.
  - Async active-low reset.
- The top level holds the FSM, the counters and the credit logic.

## Test plan
- Reset mid-stream: assert rst_n=0 during word 3 of an 8-word transfer. All outputs must be 0 in the same cycle. After release, a new start with num_words=2 streams addresses 0..1 correctly.
- Basic stream: BRAM preloaded with data = addr+0x100; start with num_words=5 and m_tready=1.
  - Required: beats 0x100..0x104 on cycles T+3..T+7, m_tlast only on 0x104, done at T+8.
- Backpressure: num_words=6, m_tready toggling 1,0,0,1,... and held low for 10 cycles.
  - Required: exact ordered data, no duplicates or losses, and tdata/tlast stable while stalled.
  - Required: at most 1 address issued beyond FIFO capacity, with addrb holding during the stall.
- Zero length: start with num_words=0.
  - Required: done at T+1, m_tvalid never asserted, no addrb change.
- Clamp and ignore: start with num_words = DEPTH+10.
  - Required: exactly DEPTH beats, last address DEPTH−1.
  - A second start during busy is ignored, and exactly one done pulse occurs.
